uart_tx_engine: RTL

UART transmit engine that drains bytes from the UART byte FIFO, acting as its reader, and serialises each byte onto the tx line. Frame format is 8N1, LSB first.
- Consumes the FIFO's read_strobe / read_data / empty interface.
- Honours an active-high clear-to-send input.
- Reports busy and per-frame completion to the wishbone UART register block.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_engine_if.sv | 8 +
 rtl/uart_baud_tick.sv | 16 +
 rtl/uart_tx_engine.sv | 118 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame constants and baud divisor clamp.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV = 2;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_WAIT = 3'd1,
    FETCH      = 3'd2,
    START      = 3'd3,
    DATA       = 3'd4,
    PARITY     = 3'd5,
    STOP       = 3'd6
  } tx_state_e;
  function automatic logic [15:0] clamp_div(input logic [15:0] div, input int min_div);
    return div < 16'(min_div) ? 16'(min_div) : div;
  endfunction
endpackage

// File: rtl/uart_tx_engine_if.sv
// uart_tx_engine_if: byte FIFO read port; master is the reading engine, slave the FIFO.
interface uart_tx_engine_if;
  logic       fifo_empty;
  logic [7:0] fifo_read_data;
  logic       fifo_read_strobe;
  modport master (input fifo_empty, input fifo_read_data, output fifo_read_strobe);
  modport slave (output fifo_empty, output fifo_read_data, input fifo_read_strobe);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable 16-bit down-counter; bit_end flags the last clock of each bit.
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] reload,
  output logic [15:0] cnt,
  output logic        bit_end
);
  logic [15:0] cnt_q, cnt_d;
  assign cnt = cnt_q;
  assign bit_end = en && cnt_q == 16'd0;
  always_comb cnt_d = (load || bit_end) ? reload : en ? cnt_q - 16'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 16'd0 : cnt_d;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: drains the byte FIFO and serialises 8-bit LSB-first frames onto tx.
// Define UART_TX_PARITY_EN to add a parity bit (parity_odd input) between data and stop.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int MIN_DIV = UART_MIN_DIV,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic        cts,
`ifdef UART_TX_PARITY_EN
  input  logic        parity_odd,
`endif
  uart_tx_engine_if.master fifo,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);
  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] div_m1_q, div_m1_d;
  logic        tx_q, tx_d, busy_q, busy_d, strobe_q, strobe_d, done_q, done_d;
  logic [15:0] tick_cnt, reload;
  logic        bit_end, tick_en, start_ok, last_stop, par_bit;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
  assign par_bit = par_q;
  always_comb par_d = state_q == FETCH ? (^fifo.fifo_read_data) ^ parity_odd : par_q;
`else
  assign par_bit = 1'b1;
`endif
  assign start_ok = !fifo.fifo_empty && cts;
  assign tick_en = state_q inside {START, DATA, PARITY, STOP};
  assign last_stop = bit_cnt_q == 3'(STOP_BITS - 1);
  assign reload = state_q == FETCH ? clamp_div(baud_div, MIN_DIV) - 16'd1 : div_m1_q;
  uart_baud_tick u_tick (
    .clk(clk), .rst(rst), .load(state_q == FETCH), .en(tick_en),
    .reload(reload), .cnt(tick_cnt), .bit_end(bit_end)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_m1_d = div_m1_q;
    done_d = 1'b0;
    case (state_q)
      IDLE:       state_d = start_ok ? FETCH_WAIT : IDLE;
      FETCH_WAIT: state_d = fifo.fifo_empty ? IDLE : FETCH;
      FETCH: begin
        shift_d = fifo.fifo_read_data;
        div_m1_d = reload;
        bit_cnt_d = 3'd0;
        state_d = START;
      end
      START:      state_d = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
          bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY:     state_d = bit_end ? STOP : PARITY;
      STOP: begin
        // registered pulse must land on the final stop clock, so fire one count early
        done_d = last_stop && tick_cnt == 16'd1;
        if (bit_end) begin
          if (last_stop) state_d = start_ok ? FETCH_WAIT : IDLE;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default:    state_d = IDLE;
    endcase
  end
  assign tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] :
                state_d == PARITY ? par_bit : 1'b1;
  assign busy_d = state_d != IDLE;
  assign strobe_d = state_d == FETCH;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= 8'd0;
      bit_cnt_q <= 3'd0;
      div_m1_q <= 16'd0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      strobe_q <= 1'b0;
      done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_m1_q <= div_m1_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      strobe_q <= strobe_d;
      done_q <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  assign tx = tx_q;
  assign busy = busy_q;
  assign frame_done = done_q;
  assign fifo.fifo_read_strobe = strobe_q;
endmodule
